mpc_mac_pipe_signed: RTL and testbench

// Parametrised, pipelined signed multiply-accumulate unit for the MPC datapath.

---
 rtl/mpc_mac_pipe_signed.sv | 113 +++++++++++
 tb/tb_mpc_mac_pipe_signed.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mpc_mac_pipe_signed.sv
// rtl/mpc_mac_pipe_signed.sv - pipelined signed MAC with load/accumulate, output shift and overflow flag
// Optional MPC_MAC_SAT_EN: clamp out-of-range results instead of two's-complement wrap.
module mpc_mac_pipe_signed #(
    parameter int DIN0_WIDTH = 21,
    parameter int DIN1_WIDTH = 10,
    parameter int NUM_STAGE  = 4,
    parameter int ACC_WIDTH  = 40,
    parameter int DOUT_WIDTH = 31,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         in_acc,
    output logic                         out_valid,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int FD = NUM_STAGE - 1;

    logic signed [DIN0_WIDTH-1:0] a_r;
    logic signed [DIN1_WIDTH-1:0] b_r;
    logic        [FD-1:0]         v_sr;
    logic        [FD-1:0]         m_sr;
    logic signed [PW-1:0]         prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r  <= '0;
            b_r  <= '0;
            v_sr <= '0;
            m_sr <= '0;
        end else if (ce) begin
            a_r     <= din0;
            b_r     <= din1;
            v_sr[0] <= in_valid;
            m_sr[0] <= in_acc;
            for (int i = 1; i < FD; i++) begin
                v_sr[i] <= v_sr[i-1];
                m_sr[i] <= m_sr[i-1];
            end
        end
    end

    // Product registers: one multiply stage plus NUM_STAGE-3 balancing stages.
    generate
        if (NUM_STAGE == 2) begin : g_comb_mul
            assign prod = a_r * b_r;
        end else begin : g_reg_mul
            logic signed [PW-1:0] p_sr [NUM_STAGE-2];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < NUM_STAGE-2; i++) p_sr[i] <= '0;
                end else if (ce) begin
                    p_sr[0] <= a_r * b_r;
                    for (int i = 1; i < NUM_STAGE-2; i++) p_sr[i] <= p_sr[i-1];
                end
            end
            assign prod = p_sr[NUM_STAGE-3];
        end
    endgenerate

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [ACC_WIDTH-1:0]  res;
    logic [ACC_WIDTH-DOUT_WIDTH:0] hi;
    logic                         ovf_c;
    logic signed [DOUT_WIDTH-1:0] dout_c;
    logic                         v_d;
    logic                         m_d;

    assign v_d = v_sr[FD-1];
    assign m_d = m_sr[FD-1];

    always_comb begin
        acc_next = m_d ? acc + ACC_WIDTH'(prod) : ACC_WIDTH'(prod);
        res      = acc_next >>> OUT_SHIFT;
        // Result fits iff every bit from the DOUT sign bit upward agrees.
        hi       = res[ACC_WIDTH-1:DOUT_WIDTH-1];
        ovf_c    = !((&hi) || !(|hi));
`ifdef MPC_MAC_SAT_EN
        if (ovf_c)
            dout_c = res[ACC_WIDTH-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        else
            dout_c = res[DOUT_WIDTH-1:0];
`else
        dout_c = res[DOUT_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= v_d;
            if (v_d) begin
                acc  <= acc_next;
                dout <= dout_c;
                ovf  <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_mpc_mac_pipe_signed.sv
// tb/tb_mpc_mac_pipe_signed.sv - scoreboard bench for mpc_mac_pipe_signed (shift 0 and shift 4 instances)
module tb_mpc_mac_pipe_signed;

    localparam int NS = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic               in_valid;
    logic signed [20:0] din0;
    logic signed [9:0]  din1;
    logic               in_acc;
    logic               out_valid0, out_valid1;
    logic signed [30:0] dout0, dout1;
    logic               ovf0, ovf1;

    always #5 clk = ~clk;

    mpc_mac_pipe_signed u_dut0 (
        .clk(clk), .reset(rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .in_acc(in_acc), .out_valid(out_valid0), .dout(dout0), .ovf(ovf0)
    );

    mpc_mac_pipe_signed #(.OUT_SHIFT(4)) u_dut1 (
        .clk(clk), .reset(rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .in_acc(in_acc), .out_valid(out_valid1), .dout(dout1), .ovf(ovf1)
    );

    typedef struct {
        longint d0;
        longint o0;
        longint d1;
        longint o1;
        longint ec;
    } exp_t;

    exp_t   sbq[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint macc    = 0;
    longint ecnt    = 0;
    logic   ce_q    = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        longint w;
        w = v & ((64'sd1 <<< 40) - 1);
        if (w >= (64'sd1 <<< 39)) w = w - (64'sd1 <<< 40);
        return w;
    endfunction

    function automatic void model_out(input longint a, input int sh, output longint d, output longint o);
        longint r, mx, mn;
        r  = a >>> sh;
        mx = (64'sd1 <<< 30) - 1;
        mn = -(64'sd1 <<< 30);
        o  = (r > mx || r < mn) ? 1 : 0;
`ifdef MPC_MAC_SAT_EN
        d = (r > mx) ? mx : (r < mn) ? mn : r;
`else
        d = r & ((64'sd1 <<< 31) - 1);
        if (d >= (64'sd1 <<< 30)) d = d - (64'sd1 <<< 31);
`endif
    endfunction

    always @(posedge clk) begin
        ce_q <= ce & ~rst;
        if (ce && !rst) ecnt <= ecnt + 1;
    end

    always @(negedge clk) begin
        if (!rst && ce_q) begin
            check("valid_pair", longint'(out_valid1), longint'(out_valid0));
            if (out_valid0) begin
                if (sbq.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("dout_sh0", longint'(dout0), e.d0);
                    check("ovf_sh0",  longint'(ovf0),  e.o0);
                    check("dout_sh4", longint'(dout1), e.d1);
                    check("ovf_sh4",  longint'(ovf1),  e.o1);
                    check("latency",  ecnt - e.ec, NS);
                end
            end
        end
    end

    task automatic drive(input int a, input int b, input bit acc_flag);
        exp_t e;
        longint p;
        din0     = 21'(a);
        din1     = 10'(b);
        in_acc   = acc_flag;
        in_valid = 1'b1;
        p    = longint'(a) * longint'(b);
        macc = wrap_acc(acc_flag ? macc + p : p);
        model_out(macc, 0, e.d0, e.o0);
        model_out(macc, 4, e.d1, e.o1);
        e.ec = ecnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0; in_acc = 1'b0;
        idle(2);
        check("rst_out_valid", longint'(out_valid0), 0);
        check("rst_dout", longint'(dout0), 0);
        check("rst_ovf", longint'(ovf0), 0);
        rst = 1'b0;
        idle(2);

        drive(-1048576, -512, 0);
        idle(8);
        check("single_dout_const", longint'(dout0), 536870912);

        drive(1000, 3, 0);
        for (int i = 0; i < 3; i++) drive(1000, 3, 1);
        idle(8);
        check("accum_final_const", longint'(dout0), 12000);

        drive(-1048576, -512, 0);
        drive(-1048576, -512, 1);
        drive(-1048576, -512, 1);
        idle(8);
        check("ovf_third", longint'(ovf0), 1);

        drive(-100, 1, 0);
        idle(8);
        check("shift_floor_const", longint'(dout1), -7);

        // Stall with two samples in flight; samples offered during the stall must vanish.
        drive(250, -7, 0);
        drive(-33, 11, 1);
        ce = 1'b0;
        din0 = 21'sd999; din1 = 10'sd99; in_acc = 1'b1; in_valid = 1'b1;
        idle(3);
        in_valid = 1'b0;
        ce = 1'b1;
        idle(10);

        drive(7, 5, 0);
        drive(7, 5, 1);
        drive(7, 5, 1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", longint'(out_valid0), 0);
        check("midrst_dout0", longint'(dout0), 0);
        check("midrst_dout1", longint'(dout1), 0);
        sbq.delete();
        macc = 0;
        idle(2);
        rst = 1'b0;
        idle(10);
        drive(12, -3, 0);
        drive(-4, 2, 1);

        for (int i = 0; i < 50 && sbq.size() > 0; i++) @(posedge clk);
        #1;
        check("drain", longint'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
